// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq
// Brief    : Multicycle RV32I fetch sequencer. Owns the PC, issues a single
//            outstanding instruction-memory read, strobes the IR load enable
//            on the response and hands the instruction to the backend over a
//            valid/ready handshake. Handles redirects, flushes, halt,
//            misaligned-target faults and a memory-response watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h1ECEB000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic        imem_resp,
    output logic        load_ir,
    output logic [31:0] pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        halt,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_DEC   = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    // Last watchdog value tolerated; a WAIT cycle starting at this value
    // without a response is the TIMEOUT-th one and faults.
    localparam logic [15:0] c_WD_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_flush_pend;
    logic        w_flush_pend_nxt;
    logic [15:0] r_wd;
    logic [15:0] w_wd_nxt;
    logic [31:0] r_fetch_count;
    logic [31:0] w_fetch_count_nxt;
    logic        r_fault;
    logic        w_fault_nxt;

    logic        w_handshake;
    logic        w_flush_misaligned;
    logic        w_redirect_misaligned;

    assign w_handshake           = (r_state == S_DEC) && dec_ready;
    assign w_flush_misaligned    = (flush_pc[1:0] != 2'b00);
    assign w_redirect_misaligned = (redirect_pc[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: PC, pending-flush marker, watchdog, counter, fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_flush_pend  <= 1'b0;
            r_wd          <= 16'd0;
            r_fetch_count <= 32'd0;
            r_fault       <= 1'b0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_flush_pend  <= w_flush_pend_nxt;
            r_wd          <= w_wd_nxt;
            r_fetch_count <= w_fetch_count_nxt;
            r_fault       <= w_fault_nxt;
        end
    end

    // Next-state and datapath update; flush outranks every other event
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_flush_pend_nxt  = r_flush_pend;
        w_wd_nxt          = r_wd;
        w_fetch_count_nxt = r_fetch_count;

        case (r_state)
            S_REQ: begin
                if (flush) begin
                    // Request suppressed this cycle; refetch from the new target
                    w_pc_nxt    = flush_pc;
                    w_state_nxt = w_flush_misaligned ? S_FAULT : S_REQ;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_wd_nxt    = 16'd0;
                end
            end

            S_WAIT: begin
                if (flush) begin
                    w_pc_nxt = flush_pc;
                    if (w_flush_misaligned) begin
                        w_state_nxt      = S_FAULT;
                        w_flush_pend_nxt = 1'b0;
                    end else if (imem_resp) begin
                        // Read completes in the same cycle: drop it and refetch
                        w_state_nxt      = S_REQ;
                        w_flush_pend_nxt = 1'b0;
                    end else begin
                        // Keep waiting so the in-flight read is not abandoned;
                        // its data is discarded when it arrives
                        w_flush_pend_nxt = 1'b1;
                        if (r_wd < c_WD_LAST) begin
                            w_wd_nxt = r_wd + 16'd1;
                        end
                    end
                end else if (imem_resp) begin
                    w_flush_pend_nxt = 1'b0;
                    w_state_nxt      = r_flush_pend ? S_REQ : S_DEC;
                end else if (r_wd >= c_WD_LAST) begin
                    w_state_nxt = S_FAULT;
                end else begin
                    w_wd_nxt = r_wd + 16'd1;
                end
            end

            S_DEC: begin
                if (flush) begin
                    // Held instruction is dropped and not counted
                    w_pc_nxt    = flush_pc;
                    w_state_nxt = w_flush_misaligned ? S_FAULT : S_REQ;
                end else if (w_handshake) begin
                    w_fetch_count_nxt = r_fetch_count + 32'd1;
                    if (halt) begin
                        w_state_nxt = S_HALT;
                    end else if (redirect) begin
                        w_pc_nxt    = redirect_pc;
                        w_state_nxt = w_redirect_misaligned ? S_FAULT : S_REQ;
                    end else begin
                        w_pc_nxt    = r_pc + 32'd4;
                        w_state_nxt = S_REQ;
                    end
                end
            end

            default: begin
                // HALT and FAULT hold until reset
                w_state_nxt = r_state;
            end
        endcase

        w_fault_nxt = r_fault | (w_state_nxt == S_FAULT);
    end

    // State-decoded outputs, forced low while reset is asserted
    always_comb begin
        imem_rmask = 4'h0;
        load_ir    = 1'b0;
        dec_valid  = 1'b0;
        halted     = 1'b0;
        if (rst_n) begin
            if ((r_state == S_REQ) && !flush) begin
                imem_rmask = 4'hF;
            end
            load_ir   = (r_state == S_WAIT) && imem_resp && !r_flush_pend && !flush;
            dec_valid = (r_state == S_DEC);
            halted    = (r_state == S_HALT);
        end
    end

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign fetch_count = r_fetch_count;
    assign fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_seq
// Brief    : Directed bench for fetch_seq with a transaction-level reference
//            model checked every cycle, plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_seq;

    localparam logic [31:0] RST_PC = 32'h1ECEB000;
    localparam int          TO     = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic        imem_resp;
    logic        load_ir;
    logic [31:0] pc;
    logic        dec_valid;
    logic        dec_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] flush_pc;
    logic        halt;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_seq #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_rmask  (imem_rmask),
        .imem_resp   (imem_resp),
        .load_ir     (load_ir),
        .pc          (pc),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .halt        (halt),
        .halted      (halted),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    // Reference model: what the fetch unit is doing, in transaction terms
    logic [31:0] m_pc       = RST_PC;
    logic [31:0] m_count    = 32'd0;
    bit          m_fault    = 1'b0;
    bit          m_halted   = 1'b0;
    bit          m_inflight = 1'b0;  // a read has been issued, no response yet
    bit          m_discard  = 1'b0;  // that read's data must be thrown away
    bit          m_hold     = 1'b0;  // an instruction is offered to the backend
    int          m_waited   = 0;

    always @(posedge clk or negedge rst_n) begin : model
        logic [31:0] n_pc;
        logic [31:0] n_cnt;
        bit          n_fault;
        bit          n_halted;
        bit          n_inflight;
        bit          n_discard;
        bit          n_hold;
        int          n_waited;
        if (!rst_n) begin
            m_pc       <= RST_PC;
            m_count    <= 32'd0;
            m_fault    <= 1'b0;
            m_halted   <= 1'b0;
            m_inflight <= 1'b0;
            m_discard  <= 1'b0;
            m_hold     <= 1'b0;
            m_waited   <= 0;
        end else begin
            n_pc = m_pc; n_cnt = m_count; n_fault = m_fault; n_halted = m_halted;
            n_inflight = m_inflight; n_discard = m_discard; n_hold = m_hold;
            n_waited = m_waited;
            if (!(n_fault || n_halted)) begin
                if (flush) begin
                    n_pc = flush_pc;
                    if (flush_pc[1:0] != 2'b00) begin
                        n_fault = 1'b1; n_hold = 1'b0; n_inflight = 1'b0;
                    end else if (n_hold) begin
                        n_hold = 1'b0;
                    end else if (n_inflight) begin
                        if (imem_resp) begin
                            n_inflight = 1'b0; n_discard = 1'b0;
                        end else begin
                            n_discard = 1'b1; n_waited = n_waited + 1;
                        end
                    end
                end else if (n_hold) begin
                    if (dec_ready) begin
                        n_cnt  = n_cnt + 32'd1;
                        n_hold = 1'b0;
                        if (halt) begin
                            n_halted = 1'b1;
                        end else if (redirect) begin
                            n_pc = redirect_pc;
                            if (redirect_pc[1:0] != 2'b00) n_fault = 1'b1;
                        end else begin
                            n_pc = n_pc + 32'd4;
                        end
                    end
                end else if (n_inflight) begin
                    if (imem_resp) begin
                        n_inflight = 1'b0; n_hold = !n_discard; n_discard = 1'b0;
                    end else begin
                        n_waited = n_waited + 1;
                        if (n_waited >= TO) begin
                            n_fault = 1'b1; n_inflight = 1'b0;
                        end
                    end
                end else begin
                    n_inflight = 1'b1; n_waited = 0;
                end
            end
            m_pc <= n_pc; m_count <= n_cnt; m_fault <= n_fault; m_halted <= n_halted;
            m_inflight <= n_inflight; m_discard <= n_discard; m_hold <= n_hold;
            m_waited <= n_waited;
        end
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle after inputs settle
    always @(negedge clk) begin
        #2;
        chk32("imem_addr", imem_addr, m_pc);
        chk32("pc", pc, m_pc);
        chk32("fetch_count", fetch_count, m_count);
        chk32("imem_rmask", {28'h0, imem_rmask},
              (rst_n && !m_fault && !m_halted && !m_inflight && !m_hold && !flush)
              ? 32'hF : 32'h0);
        chk1("load_ir", load_ir,
             rst_n && !m_fault && m_inflight && imem_resp && !m_discard && !flush);
        chk1("dec_valid", dec_valid, rst_n && m_hold);
        chk1("halted", halted, rst_n && m_halted);
        chk1("fault", fault, m_fault);
    end

    task automatic step(input logic resp, input logic rdy, input logic rd,
                        input logic [31:0] rpc, input logic fl,
                        input logic [31:0] fpc, input logic hl);
        @(negedge clk);
        imem_resp = resp; dec_ready = rdy; redirect = rd; redirect_pc = rpc;
        flush = fl; flush_pc = fpc; halt = hl;
    endtask

    task automatic cyc(input logic resp, input logic rdy);
        step(resp, rdy, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reset pulse entirely between two rising edges
    task automatic pulse_reset(input logic resp);
        step(resp, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1 rst_n = 1'b0;
        #2;
        chk1("prst_fault", fault, 1'b0);
        chk32("prst_pc", pc, RST_PC);
        chk32("prst_rmask", {28'h0, imem_rmask}, 32'h0);
        chk1("prst_model_fault", m_fault, 1'b0);
        rst_n = 1'b1;
        #1;
        chk32("prst_rmask_rel", {28'h0, imem_rmask}, 32'hF);
    endtask

    initial begin
        rst_n = 1'b0; imem_resp = 1'b0; dec_ready = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; flush = 1'b0; flush_pc = 32'h0; halt = 1'b0;

        // Reset values
        cyc(1'b0, 1'b0); #3;
        chk32("rst_pc", pc, 32'h1ECEB000);
        chk32("rst_cnt", fetch_count, 32'd0);
        chk1("rst_fault", fault, 1'b0);
        chk32("rst_rmask", {28'h0, imem_rmask}, 32'h0);
        chk32("rst_model_pc", m_pc, 32'h1ECEB000);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back fetches with one-cycle memory latency
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1); #3;
            chk32("seq_addr", imem_addr, 32'h1ECEB000 + 32'(4 * i));
            chk32("seq_rmask", {28'h0, imem_rmask}, 32'hF);
            chk32("seq_model_pc", m_pc, 32'h1ECEB000 + 32'(4 * i));
            cyc(1'b1, 1'b1); #3;
            chk1("seq_load_ir", load_ir, 1'b1);
            cyc(1'b0, 1'b1); #3;
            chk1("seq_dec_valid", dec_valid, 1'b1);
        end
        cyc(1'b0, 1'b1); #3;
        chk32("seq_count", fetch_count, 32'd3);
        chk32("seq_addr3", imem_addr, 32'h1ECEB00C);
        chk32("seq_model_count", m_count, 32'd3);

        // Backend stall for five cycles
        cyc(1'b1, 1'b0);
        repeat (5) cyc(1'b0, 1'b0);
        #3;
        chk32("stall_pc", pc, 32'h1ECEB00C);
        chk1("stall_valid", dec_valid, 1'b1);
        chk32("stall_rmask", {28'h0, imem_rmask}, 32'h0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1); #3;
        chk32("stall_addr_next", imem_addr, 32'h1ECEB010);
        chk32("stall_count", fetch_count, 32'd4);

        // Redirect, then redirect together with halt
        cyc(1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h1ECEB100, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1); #3;
        chk32("redir_addr", imem_addr, 32'h1ECEB100);
        chk32("redir_model_pc", m_pc, 32'h1ECEB100);
        cyc(1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h1ECEB300, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b1); #3;
        chk1("halt_halted", halted, 1'b1);
        chk32("halt_rmask", {28'h0, imem_rmask}, 32'h0);
        chk32("halt_count", fetch_count, 32'd6);
        step(1'b1, 1'b1, 1'b1, 32'h1ECEB400, 1'b1, 32'h1ECEB500, 1'b1);
        cyc(1'b0, 1'b0); #3;
        chk32("halt_pc", pc, 32'h1ECEB100);
        chk1("halt_stays", halted, 1'b1);

        // Flush during WAIT with the response three cycles later
        do_reset();
        cyc(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1ECEB200, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0); #3;
        chk1("fl_load_ir", load_ir, 1'b0);
        cyc(1'b0, 1'b0); #3;
        chk32("fl_addr", imem_addr, 32'h1ECEB200);
        chk32("fl_rmask", {28'h0, imem_rmask}, 32'hF);

        // Flush coincident with the response
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1ECEB240, 1'b0); #3;
        chk1("flr_load_ir", load_ir, 1'b0);
        cyc(1'b0, 1'b0); #3;
        chk32("flr_addr", imem_addr, 32'h1ECEB240);
        chk32("flr_rmask", {28'h0, imem_rmask}, 32'hF);

        // Flush while an instruction is offered: dropped, not counted
        cyc(1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1ECEB280, 1'b0);
        // Flush during REQ suppresses the request
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1ECEB2C0, 1'b0); #3;
        chk32("fld_pc", pc, 32'h1ECEB280);
        chk32("fld_count", fetch_count, 32'd0);
        chk32("flq_rmask", {28'h0, imem_rmask}, 32'h0);
        cyc(1'b0, 1'b1); #3;
        chk32("flq_addr", imem_addr, 32'h1ECEB2C0);
        chk32("flq_rmask2", {28'h0, imem_rmask}, 32'hF);

        // Misaligned redirect target
        cyc(1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h1ECEB102, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1); #3;
        chk1("mis_fault", fault, 1'b1);
        chk32("mis_pc", pc, 32'h1ECEB102);
        chk32("mis_rmask", {28'h0, imem_rmask}, 32'h0);
        chk32("mis_count", fetch_count, 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1ECEB000, 1'b0);
        cyc(1'b0, 1'b0); #3;
        chk1("mis_fault_sticky", fault, 1'b1);
        chk32("mis_pc_kept", pc, 32'h1ECEB102);

        // Watchdog: no response ever
        do_reset();
        cyc(1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0); #3;
        chk1("to_fault_pre", fault, 1'b0);
        cyc(1'b0, 1'b0); #3;
        chk1("to_fault", fault, 1'b1);
        chk1("to_model_fault", m_fault, 1'b1);

        // Async reset clears the fault; then reset mid-WAIT with a late response
        pulse_reset(1'b0);
        cyc(1'b0, 1'b0);
        pulse_reset(1'b1);
        cyc(1'b0, 1'b0); #3;
        chk1("late_load_ir", load_ir, 1'b0);
        cyc(1'b1, 1'b1); #3;
        chk1("late_load_ir2", load_ir, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0); #3;
        chk32("late_count", fetch_count, 32'd1);
        chk32("late_addr", imem_addr, 32'h1ECEB004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
